polylut_host: RTL and testbench

- Host-side driver for the polylut inference core; the opposite end of its address/M2 interface.
- Accepts 64-bit input feature vectors on a valid/ready stream and drives them onto the core's `address` bus.
- Tracks in-flight lookups through the core's fixed pipeline latency, captures each 20-bit M2 result, and returns results in order on a valid/ready output stream.
- Credit-based flow control guarantees no result is lost under output backpressure.

---
 rtl/polylut_host_pkg.sv | 23 ++
 rtl/polylut_host_if.sv | 31 +++
 rtl/polylut_host_fifo.sv | 77 +++++++
 rtl/polylut_host.sv | 134 +++++++++++++
 tb/tb_polylut_host.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/polylut_host_pkg.sv
// polylut_pkg: shared defaults for the polylut host and the pointer-width helper.
//   ADDR_W     : input vector / core address width
//   OUT_W      : core result width
//   LAT        : core latency in clock edges (1..8)
//   FIFO_DEPTH : result buffer entries (power of two, >= LAT+1)
package polylut_pkg;

    localparam int unsigned ADDR_W     = 64;
    localparam int unsigned OUT_W      = 20;
    localparam int unsigned LAT        = 2;
    localparam int unsigned FIFO_DEPTH = 4;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/polylut_host_if.sv
// polylut_host_if: bus bundle between the host, its upstream producer,
// its downstream consumer and the polylut core.
//   in_valid/in_ready/in_data    : input vector stream
//   lut_address/lut_m2           : core address out, core result in
//   out_valid/out_ready/out_data : result stream
// Modports: master = host side, slave = environment side.
interface polylut_host_if #(
    parameter int unsigned ADDR_W = polylut_pkg::ADDR_W,
    parameter int unsigned OUT_W  = polylut_pkg::OUT_W
) ();

    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_data;
    logic [ADDR_W-1:0] lut_address;
    logic [OUT_W-1:0]  lut_m2;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;

    modport master (
        input  in_valid, in_data, lut_m2, out_ready,
        output in_ready, lut_address, out_valid, out_data
    );

    modport slave (
        output in_valid, in_data, lut_m2, out_ready,
        input  in_ready, lut_address, out_valid, out_data
    );

endinterface

// File: rtl/polylut_host_fifo.sv
// polylut_host_fifo: synchronous result FIFO, head entry visible on rdata_o.
//   clk, rst (async, active-low)
//   push_i/wdata_i : write, ignored when full
//   pop_i          : read, ignored when empty
//   rdata_o        : head entry
//   full_o/empty_o/count_o : occupancy
module polylut_host_fifo
    import polylut_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 20,
    localparam int unsigned PTR_W = clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok_c;
    logic             pop_ok_c;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    // Next-state: pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        push_ok_c = push_i && !full_o;
        pop_ok_c  = pop_i && !empty_o;
        mem_d     = mem_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        count_d   = count_q;
        if (push_ok_c) begin
            mem_d[wptr_q] = wdata_i;
            wptr_d        = wptr_q + PTR_W'(1);
        end
        if (pop_ok_c) begin
            rptr_d = rptr_q + PTR_W'(1);
        end
        case ({push_ok_c, pop_ok_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/polylut_host.sv
// polylut_host: host-side driver for the polylut inference core.
// Issues input vectors onto the core address bus, tracks them through the
// core's fixed latency with a valid pipe, buffers results in a FIFO and
// returns them in order. Credits (buffer slots not yet claimed by a buffered
// or in-flight result) gate in_ready so no result is ever dropped.
//   clk, rst (async, active-low)
//   bus.master : in_* stream, lut_address/lut_m2 core link, out_* stream
//   busy       : any lookup in flight or result buffered
// Optional build macro POLYLUT_HOST_PERF_EN adds saturating counters
//   perf_accepted (accepted vectors) and perf_stall (valid but blocked).
module polylut_host #(
    parameter int unsigned ADDR_W     = polylut_pkg::ADDR_W,
    parameter int unsigned OUT_W      = polylut_pkg::OUT_W,
    parameter int unsigned LAT        = polylut_pkg::LAT,
    parameter int unsigned FIFO_DEPTH = polylut_pkg::FIFO_DEPTH
) (
    input  logic           clk,
    input  logic           rst,
    polylut_host_if.master bus,
    output logic           busy
`ifdef POLYLUT_HOST_PERF_EN
    ,
    output logic [31:0]    perf_accepted,
    output logic [31:0]    perf_stall
`endif
);

    import polylut_pkg::*;

    localparam int unsigned CNT_W  = clog2(FIFO_DEPTH) + 1;
    localparam int unsigned INF_W  = clog2(LAT + 1);
    localparam int unsigned USED_W = clog2(FIFO_DEPTH + LAT + 1);

    logic [LAT-1:0]    pipe_q, pipe_d;
    logic [ADDR_W-1:0] lut_address_q, lut_address_d;
    logic [INF_W-1:0]  inflight_c;
    logic [USED_W-1:0] used_c;
    logic              in_ready_c;
    logic              issue_c;
    logic              push_c;
    logic              pop_c;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [OUT_W-1:0]  fifo_rdata;

    // Credits and issue: in_ready depends on registered state only.
    always_comb begin
        inflight_c = '0;
        for (int k = 0; k < int'(LAT); k++) begin
            inflight_c = inflight_c + INF_W'(pipe_q[k]);
        end
        used_c        = USED_W'(fifo_count) + USED_W'(inflight_c);
        in_ready_c    = (used_c < USED_W'(FIFO_DEPTH));
        issue_c       = bus.in_valid && in_ready_c;
        lut_address_d = lut_address_q;
        if (issue_c) begin
            lut_address_d = bus.in_data;
        end
        pipe_d    = '0;
        pipe_d[0] = issue_c;
        for (int k = 1; k < int'(LAT); k++) begin
            pipe_d[k] = pipe_q[k-1];
        end
        // The last pipe stage lines up with the core result for that vector.
        push_c = pipe_q[LAT-1];
        pop_c  = bus.out_ready && !fifo_empty;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_q        <= '0;
            lut_address_q <= '0;
        end else begin
            pipe_q        <= pipe_d;
            lut_address_q <= lut_address_d;
        end
    end

    polylut_host_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (OUT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_c),
        .pop_i   (pop_c),
        .wdata_i (bus.lut_m2),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Credit accounting makes a push into a full buffer unreachable.
    assert property (@(posedge clk) disable iff (!rst) !(push_c && fifo_full));

    assign bus.in_ready    = in_ready_c;
    assign bus.lut_address = lut_address_q;
    assign bus.out_valid   = !fifo_empty;
    assign bus.out_data    = fifo_rdata;
    assign busy            = (pipe_q != '0) || (fifo_count != '0);

`ifdef POLYLUT_HOST_PERF_EN
    logic [31:0] perf_accepted_q, perf_accepted_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    // Saturating event counters.
    always_comb begin
        perf_accepted_d = perf_accepted_q;
        perf_stall_d    = perf_stall_q;
        if (issue_c && (perf_accepted_q != '1)) begin
            perf_accepted_d = perf_accepted_q + 32'd1;
        end
        if (bus.in_valid && !in_ready_c && (perf_stall_q != '1)) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_accepted_q <= '0;
            perf_stall_q    <= '0;
        end else begin
            perf_accepted_q <= perf_accepted_d;
            perf_stall_q    <= perf_stall_d;
        end
    end

    assign perf_accepted = perf_accepted_q;
    assign perf_stall    = perf_stall_q;
`endif

endmodule

// File: tb/tb_polylut_host.sv
// tb_polylut_host: self-checking bench for polylut_host.
// Core model: lut_m2 = address[19:0] ^ address[39:20], arriving so that a
// vector accepted in cycle N is returned with out_valid in cycle N+LAT+1.
// Reference: every vector accepted is outstanding until popped, so
// in_ready = outstanding < FIFO_DEPTH, busy = outstanding != 0, and the
// oldest outstanding result is visible LAT+1 cycles after its acceptance.
module tb_polylut_host;
    import polylut_pkg::*;

    logic clk;
    logic rst;
    logic busy;
`ifdef POLYLUT_HOST_PERF_EN
    logic [31:0] perf_accepted;
    logic [31:0] perf_stall;
`endif

    polylut_host_if #(.ADDR_W(ADDR_W), .OUT_W(OUT_W)) bus ();

    polylut_host #(
        .ADDR_W     (ADDR_W),
        .OUT_W      (OUT_W),
        .LAT        (LAT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus.master),
        .busy (busy)
`ifdef POLYLUT_HOST_PERF_EN
        ,
        .perf_accepted (perf_accepted),
        .perf_stall    (perf_stall)
`endif
    );

    function automatic logic [OUT_W-1:0] core_fn(input logic [ADDR_W-1:0] a);
        return a[19:0] ^ a[39:20];
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One register stage after the address register gives LAT = 2 edges.
    always @(posedge clk) bus.lut_m2 <= core_fn(bus.lut_address);

    typedef struct {
        logic [OUT_W-1:0] res;
        int               cyc;
    } sb_t;

    typedef struct {
        logic [ADDR_W-1:0] din;
        logic [OUT_W-1:0]  exp_out;
    } vec_t;

    sb_t  sb[$];
    vec_t tbl[6];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one cycle, check outputs against the reference, advance.
    task automatic tick(input logic v, input logic [ADDR_W-1:0] d, input logic ordy);
        logic exp_rdy;
        logic exp_vld;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = ordy;
        exp_rdy = (sb.size() < int'(FIFO_DEPTH));
        exp_vld = (sb.size() != 0) && (sb[0].cyc + int'(LAT) + 1 <= cyc);
        chk("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
        chk("out_valid", 64'(bus.out_valid), 64'(exp_vld));
        chk("busy", 64'(busy), 64'(sb.size() != 0));
        if (exp_vld) chk("out_data", 64'(bus.out_data), 64'(sb[0].res));
        if (v && exp_rdy) sb.push_back('{res: core_fn(d), cyc: cyc});
        if (exp_vld && ordy) void'(sb.pop_front());
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nacc;
        int nval;
        int first_c;
        int last_c;
        int start_c;
        int acc_c;
        int seen_c;

        tbl[0] = '{64'h0000_0012_3450_0ABC, 20'h129F9};
        tbl[1] = '{64'h0000_0000_0000_0000, 20'h00000};
        tbl[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 20'h00000};
        tbl[3] = '{64'h0000_00FF_FFF0_0000, 20'hFFFFF};
        tbl[4] = '{64'h1234_5600_000A_BCDE, 20'hABCDE};
        tbl[5] = '{64'h0000_0000_0010_0001, 20'h00000};

        // Reset with in_valid held high.
        rst           = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = {$urandom, $urandom};
        bus.out_ready = 1'b0;
        #100;
        chk("rst_lut_address", 64'(bus.lut_address), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_data", 64'(bus.out_data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        bus.in_valid = 1'b0;
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        cyc = 0;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Single lookups: latency, value and one-cycle pulse.
        for (int i = 0; i < 6; i++) begin
            acc_c  = cyc;
            seen_c = -1;
            tick(1'b1, tbl[i].din, 1'b1);
            for (int k = 0; k < 10 && seen_c < 0; k++) begin
                if (bus.out_valid) begin
                    seen_c = cyc;
                    chk("tbl_data", 64'(bus.out_data), 64'(tbl[i].exp_out));
                end
                tick(1'b0, '0, 1'b1);
            end
            chk("tbl_latency", 64'(seen_c), 64'(acc_c + int'(LAT) + 1));
            chk("tbl_pulse", 64'(bus.out_valid), 64'd0);
        end

        // Streaming: 16 back-to-back vectors, results contiguous.
        nval = 0; first_c = -1; last_c = -1; start_c = cyc;
        for (int i = 0; i < 24; i++) begin
            if (bus.out_valid) begin
                nval++;
                if (first_c < 0) first_c = cyc;
                last_c = cyc;
            end
            if (i < 16) tick(1'b1, ADDR_W'(i), 1'b1);
            else        tick(1'b0, '0, 1'b1);
        end
        chk("stream_count", 64'(nval), 64'd16);
        chk("stream_first", 64'(first_c), 64'(start_c + int'(LAT) + 1));
        chk("stream_span", 64'(last_c - first_c), 64'd15);

        // Backpressure: exactly FIFO_DEPTH accepts, then drain in order.
        nacc = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.in_ready) nacc++;
            tick(1'b1, {$urandom, $urandom}, 1'b0);
        end
        chk("bp_accepts", 64'(nacc), 64'(FIFO_DEPTH));
        repeat (10) tick(1'b0, '0, 1'b1);
        chk("bp_ready_back", 64'(bus.in_ready), 64'd1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            tick(1'($urandom_range(0, 1)), {$urandom, $urandom}, ($urandom_range(0, 3) != 0));
        end
        repeat (12) tick(1'b0, '0, 1'b1);

        // Reset with two results buffered and two in flight.
        repeat (4) tick(1'b1, {$urandom, $urandom}, 1'b0);
        chk("mid_busy_pre", 64'(busy), 64'd1);
        chk("mid_valid_pre", 64'(bus.out_valid), 64'd1);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("mid_rst_lut_address", 64'(bus.lut_address), 64'd0);
        chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        cyc = 0;
        repeat (10) tick(1'b0, '0, 1'b1);

`ifdef POLYLUT_HOST_PERF_EN
        // 4 accepts + 3 stalls under backpressure, then 6 streamed accepts.
        repeat (7) tick(1'b1, {$urandom, $urandom}, 1'b0);
        repeat (8) tick(1'b0, '0, 1'b1);
        repeat (6) tick(1'b1, {$urandom, $urandom}, 1'b1);
        repeat (6) tick(1'b0, '0, 1'b1);
        chk("perf_accepted", 64'(perf_accepted), 64'd10);
        chk("perf_stall", 64'(perf_stall), 64'd3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
